// File: rtl/dc_bsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dc_bsp_pkg
// Description : Shared local-memory widths and write-arbitration types.
// Revision    : 1.0 - initial release
// ============================================================================
package dc_bsp_pkg;

    localparam int LOCAL_MEM_ADDR_WIDTH      = 27;
    localparam int LOCAL_MEM_DATA_WIDTH      = 512;
    localparam int LOCAL_MEM_BURST_CNT_WIDTH = 7;

    typedef enum logic {
        REQ_KERNEL = 1'b0,
        REQ_DMA    = 1'b1
    } wr_req_id_t;

    typedef struct packed {
        wr_req_id_t                             id;
        logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0]   burstcnt;
    } wr_ack_ord_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } wr_arb_state_t;

    function automatic wr_req_id_t other_req(input wr_req_id_t id);
        return (id == REQ_KERNEL) ? REQ_DMA : REQ_KERNEL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avmm_wr_ack_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : avmm_wr_ack_order_fifo
// Description : Show-ahead FIFO holding owner/length of each issued burst.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_wr_ack_order_fifo
    import dc_bsp_pkg::*;
#(
    parameter int DEPTH = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  wr_ack_ord_t din,
    output wr_ack_ord_t dout,
    output logic        full,
    output logic        empty
);

    localparam int               c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL_CNT = DEPTH[c_PTR_W:0];

    wr_ack_ord_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [c_PTR_W:0]     w_count_nxt;

    assign w_push_ok = push & ~r_full;
    assign w_pop_ok  = pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            // Flags are registered, so a pop only frees a slot for the next cycle.
            r_full  <= (w_count_nxt == c_FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/avmm_wr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avmm_wr_burst_arbiter
// Description : Burst-locked kernel/DMA write arbiter with in-order ack steering.
// Revision    : 1.0 - initial release
// ============================================================================
module avmm_wr_burst_arbiter
    import dc_bsp_pkg::*;
#(
    parameter int AVMM_ADDR_WIDTH     = LOCAL_MEM_ADDR_WIDTH,
    parameter int AVMM_DATA_WIDTH     = LOCAL_MEM_DATA_WIDTH,
    parameter int AVMM_BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
    parameter int ACK_FIFO_DEPTH      = 64
)
(
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           r0_wr,
    input  logic [AVMM_BURSTCNT_WIDTH-1:0] r0_burstcnt,
    input  logic [AVMM_ADDR_WIDTH-1:0]     r0_address,
    input  logic [AVMM_DATA_WIDTH-1:0]     r0_writedata,
    input  logic [AVMM_DATA_WIDTH/8-1:0]   r0_byteenable,
    output logic                           r0_waitreq,
    output logic                           r0_wr_ack,
    output logic [AVMM_BURSTCNT_WIDTH-1:0] r0_wr_ack_burstcnt,

    input  logic                           r1_wr,
    input  logic [AVMM_BURSTCNT_WIDTH-1:0] r1_burstcnt,
    input  logic [AVMM_ADDR_WIDTH-1:0]     r1_address,
    input  logic [AVMM_DATA_WIDTH-1:0]     r1_writedata,
    input  logic [AVMM_DATA_WIDTH/8-1:0]   r1_byteenable,
    output logic                           r1_waitreq,
    output logic                           r1_wr_ack,
    output logic [AVMM_BURSTCNT_WIDTH-1:0] r1_wr_ack_burstcnt,

    output logic                           emif_wr,
    output logic [AVMM_BURSTCNT_WIDTH-1:0] emif_burstcnt,
    output logic [AVMM_ADDR_WIDTH-1:0]     emif_address,
    output logic [AVMM_DATA_WIDTH-1:0]     emif_writedata,
    output logic [AVMM_DATA_WIDTH/8-1:0]   emif_byteenable,
    input  logic                           emif_waitreq,
    input  logic                           emif_wr_ack,

    output logic                           ack_err
);

    wr_arb_state_t                  r_state;
    wr_arb_state_t                  w_state_nxt;
    wr_req_id_t                     r_last_grant;
    logic [AVMM_BURSTCNT_WIDTH-1:0] r_beats_left;
    logic [AVMM_BURSTCNT_WIDTH-1:0] w_beats_left_nxt;

    logic                           w_grant_vld;
    wr_req_id_t                     w_grant_id;
    logic                           w_sel_r1;
    logic                           w_accept;
    logic                           w_push;
    logic                           w_pop;
    logic [AVMM_BURSTCNT_WIDTH-1:0] w_burst_len;

    wr_ack_ord_t                    w_fifo_din;
    wr_ack_ord_t                    w_fifo_dout;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;

    logic                           r_r0_ack;
    logic                           r_r1_ack;
    logic [AVMM_BURSTCNT_WIDTH-1:0] r_r0_ack_cnt;
    logic [AVMM_BURSTCNT_WIDTH-1:0] r_r1_ack_cnt;
    logic                           r_ack_err;

    // Grant selection; a full order FIFO blocks new bursts but never an in-flight one.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_full) begin
                    if (r0_wr && r1_wr) begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = other_req(r_last_grant);
                    end else if (r0_wr) begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = REQ_KERNEL;
                    end else if (r1_wr) begin
                        w_grant_vld = 1'b1;
                        w_grant_id  = REQ_DMA;
                    end
                end
            end
            ST_BURST: begin
                w_grant_vld = 1'b1;
                w_grant_id  = r_last_grant;
            end
            default: begin
                w_grant_vld = 1'b0;
            end
        endcase
        if (reset) w_grant_vld = 1'b0;
    end

    assign w_sel_r1        = (w_grant_id == REQ_DMA);
    assign emif_wr         = w_grant_vld & (w_sel_r1 ? r1_wr : r0_wr);
    assign emif_burstcnt   = w_sel_r1 ? r1_burstcnt   : r0_burstcnt;
    assign emif_address    = w_sel_r1 ? r1_address    : r0_address;
    assign emif_writedata  = w_sel_r1 ? r1_writedata  : r0_writedata;
    assign emif_byteenable = w_sel_r1 ? r1_byteenable : r0_byteenable;

    assign r0_waitreq = ~(w_grant_vld & ~w_sel_r1) | emif_waitreq;
    assign r1_waitreq = ~(w_grant_vld &  w_sel_r1) | emif_waitreq;

    assign w_accept    = emif_wr & ~emif_waitreq;
    assign w_push      = w_accept & (r_state == ST_IDLE);
    assign w_burst_len = (emif_burstcnt == '0) ? AVMM_BURSTCNT_WIDTH'(1) : emif_burstcnt;
    assign w_pop       = emif_wr_ack & ~w_fifo_empty;

    always_comb begin
        w_state_nxt      = r_state;
        w_beats_left_nxt = r_beats_left;
        case (r_state)
            ST_IDLE: begin
                if (w_push && (w_burst_len > AVMM_BURSTCNT_WIDTH'(1))) begin
                    w_state_nxt      = ST_BURST;
                    w_beats_left_nxt = w_burst_len - 1'b1;
                end
            end
            ST_BURST: begin
                if (w_accept) begin
                    w_beats_left_nxt = r_beats_left - 1'b1;
                    if (r_beats_left <= AVMM_BURSTCNT_WIDTH'(1)) begin
                        w_state_nxt      = ST_IDLE;
                        w_beats_left_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_beats_left_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beats_left <= '0;
            r_last_grant <= REQ_DMA;
        end else begin
            r_state      <= w_state_nxt;
            r_beats_left <= w_beats_left_nxt;
            if (w_push) r_last_grant <= w_grant_id;
        end
    end

    assign w_fifo_din = '{id: w_grant_id, burstcnt: LOCAL_MEM_BURST_CNT_WIDTH'(w_burst_len)};

    avmm_wr_ack_order_fifo #(
        .DEPTH (ACK_FIFO_DEPTH)
    ) u_ack_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_fifo_din),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Ack steering: the FIFO head names the owner of the oldest outstanding burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r0_ack     <= 1'b0;
            r_r1_ack     <= 1'b0;
            r_r0_ack_cnt <= '0;
            r_r1_ack_cnt <= '0;
            r_ack_err    <= 1'b0;
        end else begin
            r_r0_ack     <= w_pop & (w_fifo_dout.id == REQ_KERNEL);
            r_r1_ack     <= w_pop & (w_fifo_dout.id == REQ_DMA);
            r_r0_ack_cnt <= (w_pop && (w_fifo_dout.id == REQ_KERNEL))
                            ? AVMM_BURSTCNT_WIDTH'(w_fifo_dout.burstcnt) : '0;
            r_r1_ack_cnt <= (w_pop && (w_fifo_dout.id == REQ_DMA))
                            ? AVMM_BURSTCNT_WIDTH'(w_fifo_dout.burstcnt) : '0;
            if (emif_wr_ack && w_fifo_empty) r_ack_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            assert (emif_burstcnt != '0)
                else $error("avmm_wr_burst_arbiter: zero burstcount on first beat");
        end
    end

    assign r0_wr_ack          = r_r0_ack;
    assign r1_wr_ack          = r_r1_ack;
    assign r0_wr_ack_burstcnt = r_r0_ack_cnt;
    assign r1_wr_ack_burstcnt = r_r1_ack_cnt;
    assign ack_err            = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_avmm_wr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avmm_wr_burst_arbiter
// Description : Directed self-checking bench for avmm_wr_burst_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_wr_burst_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_wr, r1_wr;
    logic [BW-1:0] r0_burstcnt, r1_burstcnt;
    logic [AW-1:0] r0_address, r1_address;
    logic [DW-1:0] r0_writedata, r1_writedata;
    logic [DW/8-1:0] r0_byteenable, r1_byteenable;
    logic          r0_waitreq, r1_waitreq;
    logic          r0_wr_ack, r1_wr_ack;
    logic [BW-1:0] r0_wr_ack_burstcnt, r1_wr_ack_burstcnt;
    logic          emif_wr;
    logic [BW-1:0] emif_burstcnt;
    logic [AW-1:0] emif_address;
    logic [DW-1:0] emif_writedata;
    logic [DW/8-1:0] emif_byteenable;
    logic          emif_waitreq;
    logic          emif_wr_ack;
    logic          ack_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avmm_wr_burst_arbiter #(
        .AVMM_ADDR_WIDTH     (AW),
        .AVMM_DATA_WIDTH     (DW),
        .AVMM_BURSTCNT_WIDTH (BW),
        .ACK_FIFO_DEPTH      (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .r0_wr              (r0_wr),
        .r0_burstcnt        (r0_burstcnt),
        .r0_address         (r0_address),
        .r0_writedata       (r0_writedata),
        .r0_byteenable      (r0_byteenable),
        .r0_waitreq         (r0_waitreq),
        .r0_wr_ack          (r0_wr_ack),
        .r0_wr_ack_burstcnt (r0_wr_ack_burstcnt),
        .r1_wr              (r1_wr),
        .r1_burstcnt        (r1_burstcnt),
        .r1_address         (r1_address),
        .r1_writedata       (r1_writedata),
        .r1_byteenable      (r1_byteenable),
        .r1_waitreq         (r1_waitreq),
        .r1_wr_ack          (r1_wr_ack),
        .r1_wr_ack_burstcnt (r1_wr_ack_burstcnt),
        .emif_wr            (emif_wr),
        .emif_burstcnt      (emif_burstcnt),
        .emif_address       (emif_address),
        .emif_writedata     (emif_writedata),
        .emif_byteenable    (emif_byteenable),
        .emif_waitreq       (emif_waitreq),
        .emif_wr_ack        (emif_wr_ack),
        .ack_err            (ack_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_r0(input logic wr, input logic [BW-1:0] cnt, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        r0_wr = wr; r0_burstcnt = cnt; r0_address = addr; r0_writedata = data;
    endtask

    task automatic set_r1(input logic wr, input logic [BW-1:0] cnt, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        r1_wr = wr; r1_burstcnt = cnt; r1_address = addr; r1_writedata = data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0);
        emif_waitreq = 1'b0;
        emif_wr_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset = 1'b1;
        set_r0(1'b0, '0, '0, '0);
        set_r1(1'b0, '0, '0, '0);
        r0_byteenable = 4'hF;
        r1_byteenable = 4'h3;
        emif_waitreq  = 1'b0;
        emif_wr_ack   = 1'b0;

        // Reset holds outputs quiet even with a live request.
        @(negedge clk); set_r0(1'b1, 7'd1, 16'h0010, 32'h1); #1;
        check_val("rst_emif_wr", emif_wr, 0);
        check_val("rst_r0_waitreq", r0_waitreq, 1);
        check_val("rst_r1_waitreq", r1_waitreq, 1);
        @(negedge clk); #1;
        check_val("rst_r0_wr_ack", r0_wr_ack, 0);
        check_val("rst_r0_ack_cnt", r0_wr_ack_burstcnt, 0);
        check_val("rst_r1_wr_ack", r1_wr_ack, 0);
        check_val("rst_ack_err", ack_err, 0);
        r0_wr = 1'b0;
        reset = 1'b0;

        // Single kernel burst of 4.
        @(negedge clk); set_r0(1'b1, 7'd4, 16'h0100, 32'hA0); #1;
        check_val("t1_emif_wr", emif_wr, 1);
        check_val("t1_addr", emif_address, 32'h0100);
        check_val("t1_cnt", emif_burstcnt, 4);
        check_val("t1_be", emif_byteenable, 4'hF);
        check_val("t1_r0_waitreq", r0_waitreq, 0);
        check_val("t1_r1_waitreq", r1_waitreq, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); r0_writedata = 32'hA0 + i; #1;
            check_val("t1_beat_wr", emif_wr, 1);
            check_val("t1_beat_data", emif_writedata, 32'hA0 + i);
            check_val("t1_beat_r1_waitreq", r1_waitreq, 1);
        end
        @(negedge clk); r0_wr = 1'b0; #1;
        check_val("t1_idle_emif_wr", emif_wr, 0);
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t1_r0_ack", r0_wr_ack, 1);
        check_val("t1_r0_ack_cnt", r0_wr_ack_burstcnt, 4);
        check_val("t1_r1_ack", r1_wr_ack, 0);
        @(negedge clk); #1;
        check_val("t1_r0_ack_single", r0_wr_ack, 0);

        // Contention right after reset: r0 wins, r1 follows with no bubble.
        do_reset();
        @(negedge clk);
        set_r0(1'b1, 7'd2, 16'h0200, 32'hB0);
        set_r1(1'b1, 7'd2, 16'h0300, 32'hC0); #1;
        check_val("t2_first_addr", emif_address, 32'h0200);
        check_val("t2_r0_waitreq", r0_waitreq, 0);
        check_val("t2_r1_waitreq", r1_waitreq, 1);
        @(negedge clk); r0_writedata = 32'hB1; #1;
        check_val("t2_r0_beat2", emif_writedata, 32'hB1);
        check_val("t2_r1_held", r1_waitreq, 1);
        @(negedge clk); r0_wr = 1'b0; #1;
        check_val("t2_r1_wr", emif_wr, 1);
        check_val("t2_r1_addr", emif_address, 32'h0300);
        check_val("t2_r1_waitreq", r1_waitreq, 0);
        @(negedge clk); r1_writedata = 32'hC1; #1;
        check_val("t2_r1_beat2", emif_writedata, 32'hC1);
        @(negedge clk); r1_wr = 1'b0; emif_wr_ack = 1'b1; #1;
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        check_val("t2_ack0_r0", r0_wr_ack, 1);
        check_val("t2_ack0_cnt", r0_wr_ack_burstcnt, 2);
        check_val("t2_ack0_r1", r1_wr_ack, 0);
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t2_ack1_r1", r1_wr_ack, 1);
        check_val("t2_ack1_cnt", r1_wr_ack_burstcnt, 2);
        check_val("t2_ack1_r0", r0_wr_ack, 0);

        // Burst lock: r1 burst 8 under toggling waitreq, r0 waits from beat 3.
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            emif_waitreq = c[0];
            set_r1(1'b1, 7'd8, 16'h0400, 32'hD0 + k);
            set_r0(k >= 2, 7'd1, 16'h0500, 32'hE5); #1;
            check_val("t3_emif_wr", emif_wr, 1);
            check_val("t3_data", emif_writedata, 32'hD0 + k);
            check_val("t3_r0_held", r0_waitreq, 1);
            check_val("t3_r1_waitreq", r1_waitreq, emif_waitreq);
            if (!emif_waitreq) k++;
        end
        check_val("t3_beats", k, 8);
        @(negedge clk); r1_wr = 1'b0; emif_waitreq = 1'b0; #1;
        check_val("t3_r0_grant", r0_waitreq, 0);
        check_val("t3_r0_addr", emif_address, 32'h0500);
        check_val("t3_r0_wr", emif_wr, 1);
        @(negedge clk); r0_wr = 1'b0; emif_wr_ack = 1'b1; #1;
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        check_val("t3_r1_ack", r1_wr_ack, 1);
        check_val("t3_r1_ack_cnt", r1_wr_ack_burstcnt, 8);
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t3_r0_ack", r0_wr_ack, 1);
        check_val("t3_r0_ack_cnt", r0_wr_ack_burstcnt, 1);

        // FIFO full at depth 4: fifth request stalls until an ack frees a slot.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_r0(1'b1, 7'd1, 16'h0900, 32'hF0 + i); #1;
            check_val("t4_fill_wr", emif_wr, 1);
            check_val("t4_fill_waitreq", r0_waitreq, 0);
        end
        @(negedge clk); #1;
        check_val("t4_full_emif_wr", emif_wr, 0);
        check_val("t4_full_waitreq", r0_waitreq, 1);
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        check_val("t4_ack_cycle_wr", emif_wr, 0);
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t4_after_ack_wr", emif_wr, 1);
        check_val("t4_after_ack_waitreq", r0_waitreq, 0);
        check_val("t4_r0_ack", r0_wr_ack, 1);

        // Simultaneous push/pop keeps occupancy; then a spurious ack.
        @(negedge clk); r0_wr = 1'b0; emif_wr_ack = 1'b1; #1;
        @(negedge clk); set_r0(1'b1, 7'd1, 16'h0A00, 32'hE0); #1;
        check_val("t5_pushpop_wr", emif_wr, 1);
        check_val("t5_ack_a", r0_wr_ack, 1);
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t5_push_wr", emif_wr, 1);
        check_val("t5_ack_b", r0_wr_ack, 1);
        @(negedge clk); #1;
        check_val("t5_full_wr", emif_wr, 0);
        check_val("t5_full_waitreq", r0_waitreq, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); r0_wr = 1'b0; emif_wr_ack = 1'b1; #1;
            if (i > 0) check_val("t5_drain_ack", r0_wr_ack, 1);
        end
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t5_drain_last", r0_wr_ack, 1);
        check_val("t5_no_err_yet", ack_err, 0);
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t5_ack_err", ack_err, 1);
        check_val("t5_spur_r0", r0_wr_ack, 0);
        check_val("t5_spur_r1", r1_wr_ack, 0);

        // Reset in the middle of a 6-beat burst.
        @(negedge clk); set_r0(1'b1, 7'd6, 16'h0600, 32'h60); #1;
        check_val("t6_beat1_wr", emif_wr, 1);
        @(negedge clk); r0_writedata = 32'h61; reset = 1'b1; #1;
        check_val("t6_rst_emif_wr", emif_wr, 0);
        check_val("t6_rst_r0_waitreq", r0_waitreq, 1);
        check_val("t6_rst_r1_waitreq", r1_waitreq, 1);
        @(negedge clk); #1;
        check_val("t6_rst2_emif_wr", emif_wr, 0);
        check_val("t6_rst_ack_err", ack_err, 0);
        @(negedge clk); reset = 1'b0; r0_wr = 1'b0;
        @(negedge clk);
        set_r0(1'b1, 7'd2, 16'h0700, 32'h70);
        set_r1(1'b1, 7'd1, 16'h0800, 32'h80); #1;
        check_val("t6_fresh_wr", emif_wr, 1);
        check_val("t6_fresh_addr", emif_address, 32'h0700);
        check_val("t6_fresh_r0_waitreq", r0_waitreq, 0);
        check_val("t6_fresh_r1_waitreq", r1_waitreq, 1);
        @(negedge clk); r0_writedata = 32'h71; #1;
        check_val("t6_fresh_beat2", emif_writedata, 32'h71);
        @(negedge clk); r0_wr = 1'b0; #1;
        check_val("t6_r1_addr", emif_address, 32'h0800);
        check_val("t6_r1_waitreq", r1_waitreq, 0);
        @(negedge clk); r1_wr = 1'b0; emif_wr_ack = 1'b1; #1;
        @(negedge clk); emif_wr_ack = 1'b1; #1;
        check_val("t6_r0_ack", r0_wr_ack, 1);
        check_val("t6_r0_ack_cnt", r0_wr_ack_burstcnt, 2);
        @(negedge clk); emif_wr_ack = 1'b0; #1;
        check_val("t6_r1_ack", r1_wr_ack, 1);
        check_val("t6_r1_ack_cnt", r1_wr_ack_burstcnt, 1);
        check_val("t6_ack_err", ack_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avmm_wr_burst_arbiter.md
# avmm_wr_burst_arbiter

Burst-locked, two-requester write arbiter that shares one local-memory AVMM write channel between the kernel-system and the host DMA controller, ahead of the PIM AVMM-AXI conversion. It records the owner and burst length of every granted burst in an in-order FIFO. It steers each per-burst write-ack returned by the conversion back to the requester that issued the burst, together with that burst's length. The per-word expansion stage downstream consumes the `rN_wr_ack` / `rN_wr_ack_burstcnt` pair.

## Interface
Parameters:
- `AVMM_ADDR_WIDTH`, default `LOCAL_MEM_ADDR_WIDTH`: address width.
- `AVMM_DATA_WIDTH`, default `LOCAL_MEM_DATA_WIDTH`: data width; byteenable width is `AVMM_DATA_WIDTH/8`.
- `AVMM_BURSTCNT_WIDTH`, default `LOCAL_MEM_BURST_CNT_WIDTH`: burstcount width.
- `ACK_FIFO_DEPTH`, default 64: maximum outstanding (un-acked) bursts; power of 2.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `r0_wr`, `r0_burstcnt`, `r0_address`, `r0_writedata`, `r0_byteenable` in (widths per parameters): kernel write request.
- `r0_waitreq` out 1: kernel stall.
- `r0_wr_ack` out 1: one pulse per completed kernel burst.
- `r0_wr_ack_burstcnt` out `AVMM_BURSTCNT_WIDTH`: length of the acked kernel burst.
- `r1_*`: identical set for the DMA requester.
- `emif_wr`, `emif_burstcnt`, `emif_address`, `emif_writedata`, `emif_byteenable` out: merged downstream write.
- `emif_waitreq` in 1: downstream stall.
- `emif_wr_ack` in 1: one pulse per completed burst, in issue order.
- `ack_err` out 1: sticky flag, set when an ack arrives with the FIFO empty.

## Operation
State machine: `IDLE`, `BURST`.

IDLE:
- Candidates are the requesters with `rN_wr` high.
- If both request, the winner is the one not granted last (`last_grant` register).
- The winner's command is passed combinationally to `emif_*`; the loser sees `waitreq=1`.
- The winner's `waitreq` equals `emif_waitreq`.
- If the FIFO is full, nothing is granted: both `waitreq=1` and `emif_wr=0`.

First beat accepted (`emif_wr & ~emif_waitreq` in IDLE):
- Push `{id, burstcnt}` into the FIFO and set `last_grant=id`.
- If `burstcnt>1`: load `beats_left=burstcnt-1` and go to BURST.
- Otherwise stay in IDLE.

BURST:
- Grant is locked to `last_grant`, and the other requester is held with `waitreq=1`.
- The FIFO-full check does not apply, so an in-flight burst always completes.
- Each accepted beat decrements `beats_left`. The accept that takes it from 1 to 0 returns the block to IDLE, and the next IDLE cycle may grant immediately (no bubble).

Address and burstcount are meaningful downstream on the first beat only; they are passed through on every beat.

`burstcnt==0` is illegal: an assertion fires and the burst is treated as length 1.

Ack path:
- `emif_wr_ack` pops the FIFO head.
- On the next cycle, `r{head.id}_wr_ack=1` and `r{head.id}_wr_ack_burstcnt=head.burstcnt`; both are registered outputs.
- An ack with the FIFO empty is dropped and sets `ack_err`.

Boundaries:
- Push and pop in the same cycle are legal, and occupancy is unchanged.
- Push into a full FIFO cannot occur, because the grant is blocked.
- A pop on the same cycle that the FIFO reaches full frees a slot for the next cycle only.

Reset (including mid-burst):
- State goes to IDLE, the FIFO is emptied, `beats_left=0` and `ack_err=0`.
- `last_grant=1`, so r0 wins the first contention.
- In-flight acks are discarded.
- Outputs held during reset: `emif_wr=0`, `r0_waitreq=r1_waitreq=1`, `rN_wr_ack=0`, `rN_wr_ack_burstcnt=0`.

## Timing
- Command path is combinational: zero added latency and zero throughput loss; back-to-back bursts from alternating requesters sustain one beat per cycle.
- Ack path has 1-cycle latency, from the `emif_wr_ack` edge to the `rN_wr_ack` edge.
- At most one `rN_wr_ack` pulse per cycle, across both requesters.
- A FIFO pop is visible to the next grant decision one cycle later (registered `full`).
- `ack_err` is set the cycle after the offending ack and is cleared only by reset.

## Structure
Add to `dc_bsp_pkg`:
- `typedef enum logic {REQ_KERNEL=1'b0, REQ_DMA=1'b1} wr_req_id_t`.
- `typedef struct packed {wr_req_id_t id; logic [LOCAL_MEM_BURST_CNT_WIDTH-1:0] burstcnt;} wr_ack_ord_t`.

Sub-module `avmm_wr_ack_order_fifo`:
- Synchronous show-ahead FIFO of `wr_ack_ord_t`, depth `ACK_FIFO_DEPTH`.
- Ports: `push`, `pop`, `din`, `dout`, `full`, `empty`.
- Registered `full` and `empty`; a count register one bit wider than the pointer.

The arbiter FSM, beat counter and ack steering live in the top module.

## Test plan
- **Single kernel burst:** r0 burst 4 at 0x100, r1 idle. Required: 4 beats pass through with `r1_waitreq=1`. Then one `emif_wr_ack` gives `r0_wr_ack=1` with burstcnt 4 one cycle later, and `r1_wr_ack=0`.
- **Contention after reset:** r0 and r1 both request burst 2 on the same cycle. Required: r0 granted first, then r1 with no idle cycle. Two acks give an r0 pulse (cnt 2), then an r1 pulse (cnt 2).
- **Burst lock:** r1 burst 8 with `emif_waitreq` toggling every other cycle, and r0 requesting from beat 3. Required: r0 held until all 8 r1 beats are accepted; r0 granted on the following cycle.
- **FIFO full:** `ACK_FIFO_DEPTH=4`, 4 single-beat bursts, no acks. Required: the 5th request is stalled with `emif_wr=0`. An ack on cycle N lets the 5th burst issue on cycle N+1.
- **Simultaneous push/pop and spurious ack:** ack and a new first beat on the same cycle leave occupancy unchanged. An ack with the FIFO empty sets `ack_err=1` and produces no `rN_wr_ack`.
- **Reset mid-burst:** assert reset at beat 2 of a burst of 6. Required: `emif_wr=0` and both waitreq at 1 during reset. Afterwards the FIFO is empty, state is IDLE, and a fresh r0 burst is granted normally.
